// File: rtl/usb_in_transaction.sv
// usb_in_transaction
//
// Host-side USB IN transaction engine. Placed between the read/write FSM and
// the packet sender/receiver. Issues an IN token, waits for the device's
// response within a timeout, NAKs corrupt or missing data, re-issues IN after
// a device NAK, and tracks the DATA0/DATA1 toggle. The transaction ends with
// a success pulse or with a failure pulse and a failure code.
//
// Ports
//   clock, reset_n     clock (rising edge) and asynchronous active-low reset
//   start, toggle_clr  begin a transaction / force the toggle to DATA0 (IDLE only)
//   done, success,     one-cycle completion pulses; fail_code is held until the
//   failure, fail_code next accepted start (01 timeout/NAK limit, 10 invalid, 11 STALL)
//   data_out           last accepted payload
//   data_toggle        PID expected for the next data packet (0=DATA0, 1=DATA1)
//   send_IN/ACK/NAK    one-cycle requests to the packet sender
//   sent               sender finished the requested packet
//   rec_start          receiver saw the start of a packet
//   rec_DATA0/1, rec_NAK, rec_STALL  receiver end-of-packet pulses
//   data_valid, data_rec             payload qualifiers sampled with rec_DATAx
module usb_in_transaction #(
  parameter int DATA_W       = 64,
  parameter int TIMEOUT_CYC  = 255,
  parameter int MAX_TIMEOUTS = 8,
  parameter int MAX_INVALID  = 8,
  parameter int MAX_DEV_NAK  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              toggle_clr,
  output logic              done,
  output logic              success,
  output logic              failure,
  output logic [1:0]        fail_code,
  output logic [DATA_W-1:0] data_out,
  output logic              data_toggle,
  output logic              send_IN,
  output logic              send_ACK,
  output logic              send_NAK,
  input  logic              sent,
  input  logic              rec_start,
  input  logic              rec_DATA0,
  input  logic              rec_DATA1,
  input  logic              rec_NAK,
  input  logic              rec_STALL,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_rec
);

  localparam int CYC_W = $clog2(TIMEOUT_CYC + 1);
  localparam int TO_W  = $clog2(MAX_TIMEOUTS + 1);
  localparam int INV_W = $clog2(MAX_INVALID + 1);
  localparam int NAK_W = $clog2(MAX_DEV_NAK + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(MAX_TIMEOUTS - 1);
  localparam logic [INV_W-1:0] INV_LAST = INV_W'(MAX_INVALID - 1);
  localparam logic [NAK_W-1:0] NAK_LAST = NAK_W'(MAX_DEV_NAK - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_IN, S_WAIT_RESP, S_RECEIVING, S_SEND_NAK, S_SEND_ACK
  } state_t;

  state_t             state, state_nxt;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [INV_W-1:0]   inv_cnt;
  logic [NAK_W-1:0]   nak_cnt;
  logic               dup_q;
  logic               succ_now, fail_now;
  logic [1:0]         fail_code_nxt;

  // Saturating increment shared by the per-transaction event counters.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  // Event decode. The "last" flags mean the next event of that kind hits its limit.
  logic cyc_expire, in_rx, rx_term, rx_pid;
  logic start_ev, ack_sent, timeout_ev;
  logic stall_ev, nak_ev, data_ev, inv_ev, good_ev, dup_ev;
  logic to_last, inv_last, nak_last;

  assign cyc_expire = (cyc_cnt == CYC_LAST);
  assign in_rx      = (state == S_RECEIVING);
  assign rx_term    = rec_STALL | rec_NAK | rec_DATA0 | rec_DATA1;
  assign rx_pid     = rec_DATA1;
  assign start_ev   = (state == S_IDLE) & start;
  assign ack_sent   = (state == S_SEND_ACK) & sent;
  assign stall_ev   = in_rx & rec_STALL;
  assign nak_ev     = in_rx & ~rec_STALL & rec_NAK;
  assign data_ev    = in_rx & ~rec_STALL & ~rec_NAK & (rec_DATA0 | rec_DATA1);
  assign inv_ev     = data_ev & ~data_valid;
  assign good_ev    = data_ev & data_valid & (rx_pid == data_toggle);
  assign dup_ev     = data_ev & data_valid & (rx_pid != data_toggle);
  // A packet start (WAIT_RESP) or a terminator (RECEIVING) in the expiry cycle wins.
  assign timeout_ev = cyc_expire & (((state == S_WAIT_RESP) & ~rec_start) | (in_rx & ~rx_term));
  assign to_last    = (to_cnt >= TO_LAST);
  assign inv_last   = (inv_cnt >= INV_LAST);
  assign nak_last   = (nak_cnt >= NAK_LAST);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_SEND_IN;
      S_SEND_IN,
      S_SEND_NAK:  if (sent) state_nxt = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (rec_start)       state_nxt = S_RECEIVING;
        else if (cyc_expire) state_nxt = to_last ? S_IDLE : S_SEND_NAK;
      end
      S_RECEIVING: begin
        if (rec_STALL)                   state_nxt = S_IDLE;
        else if (rec_NAK)                state_nxt = nak_last ? S_IDLE : S_SEND_IN;
        else if (rec_DATA0 | rec_DATA1) begin
          if (!data_valid)               state_nxt = inv_last ? S_IDLE : S_SEND_NAK;
          else                           state_nxt = S_SEND_ACK;
        end
        else if (cyc_expire)             state_nxt = to_last ? S_IDLE : S_SEND_NAK;
      end
      S_SEND_ACK:  if (sent) state_nxt = dup_q ? S_SEND_IN : S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Output logic: sender requests go out in the deciding cycle; completion
  // is registered and appears the cycle after.
  always_comb begin
    send_IN       = start_ev | (nak_ev & ~nak_last) | (ack_sent & dup_q);
    send_NAK      = (timeout_ev & ~to_last) | (inv_ev & ~inv_last);
    send_ACK      = good_ev | dup_ev;
    succ_now      = ack_sent & ~dup_q;
    fail_now      = stall_ev | (nak_ev & nak_last) | (inv_ev & inv_last) | (timeout_ev & to_last);
    fail_code_nxt = 2'b01;
    if (stall_ev)                fail_code_nxt = 2'b11;
    else if (inv_ev & inv_last)  fail_code_nxt = 2'b10;
  end

  // Counters, payload, toggle and completion flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done        <= 1'b0;
      success     <= 1'b0;
      failure     <= 1'b0;
      fail_code   <= 2'b00;
      data_out    <= '0;
      data_toggle <= 1'b0;
      cyc_cnt     <= '0;
      to_cnt      <= '0;
      inv_cnt     <= '0;
      nak_cnt     <= '0;
      dup_q       <= 1'b0;
    end else begin
      done    <= succ_now | fail_now;
      success <= succ_now;
      failure <= fail_now;

      if (start_ev)      fail_code <= 2'b00;
      else if (fail_now) fail_code <= fail_code_nxt;

      if (start_ev) begin
        to_cnt  <= '0;
        inv_cnt <= '0;
        nak_cnt <= '0;
      end else begin
        if (timeout_ev) to_cnt  <= TO_W'(sat_inc(32'(to_cnt), MAX_TIMEOUTS));
        if (inv_ev)     inv_cnt <= INV_W'(sat_inc(32'(inv_cnt), MAX_INVALID));
        if (nak_ev)     nak_cnt <= NAK_W'(sat_inc(32'(nak_cnt), MAX_DEV_NAK));
      end

      // The cycle counter only runs while waiting; any state change restarts it.
      if (((state == S_WAIT_RESP) || (state == S_RECEIVING)) && (state_nxt == state))
        cyc_cnt <= cyc_cnt + 1'b1;
      else
        cyc_cnt <= '0;

      if ((state == S_IDLE) && toggle_clr) data_toggle <= 1'b0;
      else if (good_ev)                    data_toggle <= ~data_toggle;

      if (good_ev) data_out <= data_rec;

      // A duplicate is ACKed, then the IN is re-issued instead of finishing.
      if (dup_ev)        dup_q <= 1'b1;
      else if (ack_sent) dup_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_in_transaction.sv
// tb_usb_in_transaction
//
// Plays both the packet sender and a randomised device around
// usb_in_transaction. Each transaction is a stream of device responses chosen
// at random; a transaction-level model (plain counters per transaction plus
// the expected toggle and payload) predicts which request pulse or completion
// comes next, after how many cycles, and the final result.
module tb_usb_in_transaction;

  localparam int DW = 64;
  localparam int T  = 12;
  localparam int MT = 8;
  localparam int MI = 8;
  localparam int MN = 16;

  localparam logic [3:0] EV_IN   = 4'b0001;
  localparam logic [3:0] EV_NAK  = 4'b0010;
  localparam logic [3:0] EV_ACK  = 4'b0100;
  localparam logic [3:0] EV_DONE = 4'b1000;

  localparam int K_TO = 0, K_RXTO = 1, K_NAK = 2, K_STALL = 3, K_INV = 4, K_DUP = 5, K_GOOD = 6;

  logic          clock, reset_n, start, toggle_clr;
  logic          done, success, failure;
  logic [1:0]    fail_code;
  logic [DW-1:0] data_out;
  logic          data_toggle, send_IN, send_ACK, send_NAK;
  logic          sent, rec_start, rec_DATA0, rec_DATA1, rec_NAK, rec_STALL, data_valid;
  logic [DW-1:0] data_rec;

  int            n_tests, n_fail;
  logic [3:0]    o_vec, prev_vec;
  logic          o_success, o_failure, o_toggle;
  logic [1:0]    o_code;
  logic [DW-1:0] o_data;
  logic [DW-1:0] m_data;
  logic          m_toggle;

  usb_in_transaction #(
    .DATA_W(DW), .TIMEOUT_CYC(T), .MAX_TIMEOUTS(MT), .MAX_INVALID(MI), .MAX_DEV_NAK(MN)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .toggle_clr(toggle_clr),
    .done(done), .success(success), .failure(failure), .fail_code(fail_code),
    .data_out(data_out), .data_toggle(data_toggle),
    .send_IN(send_IN), .send_ACK(send_ACK), .send_NAK(send_NAK),
    .sent(sent), .rec_start(rec_start), .rec_DATA0(rec_DATA0), .rec_DATA1(rec_DATA1),
    .rec_NAK(rec_NAK), .rec_STALL(rec_STALL), .data_valid(data_valid), .data_rec(data_rec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs already driven, outputs sampled on the falling
  // edge, pulse inputs released just after the rising edge.
  task automatic step();
    logic [3:0] v;
    @(negedge clock);
    v = {done, send_ACK, send_NAK, send_IN};
    if (v != 4'b0) check_eq("no_back_to_back", 64'(v & prev_vec), 64'd0);
    prev_vec  = v;
    o_vec     = v;
    o_success = success;
    o_failure = failure;
    o_code    = fail_code;
    o_data    = data_out;
    o_toggle  = data_toggle;
    @(posedge clock);
    #1;
    start = 1'b0; toggle_clr = 1'b0; sent = 1'b0; rec_start = 1'b0;
    rec_DATA0 = 1'b0; rec_DATA1 = 1'b0; rec_NAK = 1'b0; rec_STALL = 1'b0; data_valid = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Wait (bounded) for the next request/completion pulse; w = idle cycles spent.
  task automatic next_event(output logic [3:0] v, output int w);
    w = 0;
    while (o_vec == 4'b0 && w < T + 6) begin
      step();
      w++;
    end
    v = o_vec;
  endtask

  // Sender completes the pending packet; stray start/toggle_clr must be ignored.
  task automatic send_done();
    idle_n(int'($urandom_range(0, 3)));
    sent = 1'b1;
    if ($urandom_range(0, 4) == 0) start = 1'b1;
    if ($urandom_range(0, 4) == 0) toggle_clr = 1'b1;
    step();
  endtask

  function automatic int pick_delay();
    if ($urandom_range(0, 3) == 0) return T - 1;
    return int'($urandom_range(0, T - 1));
  endfunction

  function automatic int pick_kind(input int mode);
    int r;
    case (mode)
      1: return ($urandom_range(0, 1) == 0) ? K_TO : K_RXTO;
      2: return K_INV;
      3: return K_NAK;
      5: return K_GOOD;
      default: begin
        r = int'($urandom_range(0, 99));
        if (r < 10) return K_TO;
        if (r < 15) return K_RXTO;
        if (r < 30) return K_NAK;
        if (r < 33) return K_STALL;
        if (r < 48) return K_INV;
        if (r < 60) return K_DUP;
        return K_GOOD;
      end
    endcase
  endfunction

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_done",     64'(done), 64'd0);
    check_eq("rst_success",  64'(success), 64'd0);
    check_eq("rst_failure",  64'(failure), 64'd0);
    check_eq("rst_code",     64'(fail_code), 64'd0);
    check_eq("rst_data_out", data_out, 64'd0);
    check_eq("rst_toggle",   64'(data_toggle), 64'd0);
    check_eq("rst_sends",    64'({send_ACK, send_NAK, send_IN}), 64'd0);
    step();
    step();
    reset_n  = 1'b1;
    m_data   = '0;
    m_toggle = 1'b0;
    prev_vec = 4'b0;
  endtask

  task automatic run_txn(input int mode);
    int to_c, inv_c, nak_c, kind, w, exp_w;
    bit fin, ok;
    logic [3:0] v, exp_v;
    logic [1:0] exp_code;
    logic [DW-1:0] d;
    logic pid;
    to_c = 0; inv_c = 0; nak_c = 0; fin = 0;
    if (mode != 5 && $urandom_range(0, 3) == 0) begin
      toggle_clr = 1'b1;
      m_toggle   = 1'b0;
    end
    start = 1'b1;
    step();
    next_event(v, w);
    check_eq("start_send_in", 64'(v), 64'(EV_IN));
    check_eq("start_latency", 64'(w), 64'd0);
    while (!fin) begin
      send_done();
      kind = pick_kind(mode);
      d    = (mode == 5) ? 64'hDEADBEEF_01234567 : {$urandom, $urandom};
      pid  = m_toggle;
      if (kind != K_TO) begin
        idle_n(pick_delay());
        rec_start = 1'b1;
        step();
        if (kind != K_RXTO) begin
          idle_n(pick_delay());
          case (kind)
            K_NAK:   rec_NAK = 1'b1;
            K_STALL: rec_STALL = 1'b1;
            default: begin
              if (kind == K_INV) pid = 1'($urandom_range(0, 1));
              if (kind == K_DUP) pid = ~m_toggle;
              rec_DATA0  = ~pid;
              rec_DATA1  = pid;
              data_valid = (kind != K_INV);
              data_rec   = d;
            end
          endcase
          step();
        end
      end
      exp_code = 2'b00;
      exp_w    = 0;
      exp_v    = EV_ACK;
      ok       = 0;
      case (kind)
        K_TO, K_RXTO: begin
          to_c++;
          exp_w = T;
          if (to_c == MT) begin fin = 1; exp_code = 2'b01; end
          else exp_v = EV_NAK;
        end
        K_STALL: begin fin = 1; exp_code = 2'b11; end
        K_NAK: begin
          nak_c++;
          if (nak_c == MN) begin fin = 1; exp_code = 2'b01; end
          else exp_v = EV_IN;
        end
        K_INV: begin
          inv_c++;
          if (inv_c == MI) begin fin = 1; exp_code = 2'b10; end
          else exp_v = EV_NAK;
        end
        default: exp_v = EV_ACK;
      endcase
      if (fin) begin
        exp_v = EV_DONE;
        exp_w = exp_w + 1;
      end
      next_event(v, w);
      check_eq("response_event", 64'(v), 64'(exp_v));
      check_eq("response_latency", 64'(w), 64'(exp_w));
      if (v !== exp_v) begin
        do_reset();
        return;
      end
      if (fin) begin
        check_eq("fail_flag",    64'(o_failure), 64'd1);
        check_eq("fail_success", 64'(o_success), 64'd0);
        check_eq("fail_code",    64'(o_code), 64'(exp_code));
        check_eq("fail_data",    o_data, m_data);
        check_eq("fail_toggle",  64'(o_toggle), 64'(m_toggle));
      end else if (exp_v == EV_ACK) begin
        send_done();
        next_event(v, w);
        if (kind == K_DUP) begin
          check_eq("dup_reissue_in", 64'(v), 64'(EV_IN));
          check_eq("dup_in_latency", 64'(w), 64'd0);
          if (v !== EV_IN) begin
            do_reset();
            return;
          end
        end else begin
          m_data   = d;
          m_toggle = ~m_toggle;
          ok       = 1;
          fin      = 1;
          check_eq("ok_done",    64'(v), 64'(EV_DONE));
          check_eq("ok_latency", 64'(w), 64'd1);
          check_eq("ok_success", 64'(o_success), 64'(ok));
          check_eq("ok_failure", 64'(o_failure), 64'd0);
          check_eq("ok_code",    64'(o_code), 64'd0);
          check_eq("ok_data",    o_data, m_data);
          check_eq("ok_toggle",  64'(o_toggle), 64'(m_toggle));
        end
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; start = 1'b0; toggle_clr = 1'b0; sent = 1'b0; rec_start = 1'b0;
    rec_DATA0 = 1'b0; rec_DATA1 = 1'b0; rec_NAK = 1'b0; rec_STALL = 1'b0;
    data_valid = 1'b0; data_rec = '0;
    o_vec = 4'b0; prev_vec = 4'b0; o_success = 1'b0; o_failure = 1'b0;
    o_code = 2'b00; o_data = '0; o_toggle = 1'b0;
    m_data = '0; m_toggle = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    run_txn(5);
    run_txn(1);
    run_txn(2);
    run_txn(3);
    for (int i = 0; i < 40; i++) run_txn(0);

    // Reset while the engine is waiting for a response.
    start = 1'b1;
    step();
    check_eq("mid_send_in", 64'(o_vec), 64'(EV_IN));
    send_done();
    idle_n(3);
    do_reset();
    for (int i = 0; i < 10; i++) run_txn(0);
    run_txn(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
